// File: rtl/tour_pkg.sv
// Shared constants and state encoding for the knight's-tour command replayer.
package tour_pkg;

    localparam logic [3:0] OPC_MOVE    = 4'b0010;
    localparam logic [3:0] OPC_FANFARE = 4'b0011;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        V_CMD,
        V_HOLD,
        H_CMD,
        H_HOLD
    } state_t;

endpackage

// File: rtl/tour_cmd_if.sv
// Command handshake between the tour replayer (master) and cmd_proc (slave).
interface tour_cmd_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output cmd_rdy,
        output resp,
        input  clr_cmd_rdy,
        input  send_resp
    );

    modport slave (
        input  cmd,
        input  cmd_rdy,
        input  resp,
        output clr_cmd_rdy,
        output send_resp
    );

endinterface

// File: rtl/tour_move_decode.sv
// Combinational one-hot knight move -> {heading, squares} for the vertical and horizontal legs.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [11:0] vert_cmd,
    output logic [11:0] horiz_cmd,
    output logic        valid
);

    always_comb begin
        vert_cmd  = '0;
        horiz_cmd = '0;
        valid     = 1'b1;
        unique case (move)
            8'h01: begin vert_cmd = {HDG_N, 4'd2}; horiz_cmd = {HDG_W, 4'd1}; end
            8'h02: begin vert_cmd = {HDG_N, 4'd2}; horiz_cmd = {HDG_E, 4'd1}; end
            8'h04: begin vert_cmd = {HDG_N, 4'd1}; horiz_cmd = {HDG_W, 4'd2}; end
            8'h08: begin vert_cmd = {HDG_S, 4'd1}; horiz_cmd = {HDG_W, 4'd2}; end
            8'h10: begin vert_cmd = {HDG_S, 4'd2}; horiz_cmd = {HDG_W, 4'd1}; end
            8'h20: begin vert_cmd = {HDG_S, 4'd2}; horiz_cmd = {HDG_E, 4'd1}; end
            8'h40: begin vert_cmd = {HDG_S, 4'd1}; horiz_cmd = {HDG_E, 4'd2}; end
            8'h80: begin vert_cmd = {HDG_N, 4'd1}; horiz_cmd = {HDG_E, 4'd2}; end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Replays the solved tour as vertical/horizontal motion commands; passes UART commands through when idle.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24,
    parameter int unsigned IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    tour_cmd_if.master       bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t      state, state_nxt;
    logic        idx_inc, idx_clr;
    logic        last_move;
    logic [11:0] vert_cmd, horiz_cmd;
    logic        move_valid;

    tour_move_decode u_decode (
        .move      (move),
        .vert_cmd  (vert_cmd),
        .horiz_cmd (horiz_cmd),
        .valid     (move_valid)
    );

    assign last_move = (mv_indx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state <= state_nxt;
            if (idx_clr)
                mv_indx <= '0;
            else if (idx_inc)
                mv_indx <= mv_indx + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_inc     = 1'b0;
        idx_clr     = 1'b0;
        bus.cmd     = '0;
        bus.cmd_rdy = 1'b0;
        bus.resp    = RESP_ACK;
        unique case (state)
            IDLE: begin
                bus.cmd     = cmd_UART;
                bus.cmd_rdy = cmd_rdy_UART;
                bus.resp    = RESP_DONE;
                if (start_tour)
                    state_nxt = V_CMD;
            end
            V_CMD, V_HOLD: begin
                bus.cmd     = move_valid ? {OPC_MOVE, vert_cmd} : '0;
                bus.cmd_rdy = (state == V_CMD);
                // A send_resp coinciding with the consume skips V_HOLD entirely.
                if (state == V_CMD) begin
                    if (bus.clr_cmd_rdy)
                        state_nxt = bus.send_resp ? H_CMD : V_HOLD;
                end else if (bus.send_resp) begin
                    state_nxt = H_CMD;
                end
            end
            H_CMD, H_HOLD: begin
                bus.cmd     = move_valid ? {(last_move ? OPC_FANFARE : OPC_MOVE), horiz_cmd} : '0;
                bus.cmd_rdy = (state == H_CMD);
                if (state == H_HOLD && last_move)
                    bus.resp = RESP_DONE;
                if (state == H_CMD && bus.clr_cmd_rdy && !bus.send_resp)
                    state_nxt = H_HOLD;
                // H_CMD with both strobes finishes the move just as H_HOLD would.
                if (bus.send_resp && (state == H_HOLD || bus.clr_cmd_rdy)) begin
                    if (last_move) begin
                        idx_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = V_CMD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed self-checking bench for tour_cmd.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic rdy_prev = 1'b0;

    tour_cmd_if tcif ();

    tour_cmd #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .bus          (tcif)
    );

    always #5 clk = ~clk;

    // Rising edges of cmd_rdy, sampled away from the active edge.
    always @(negedge clk) begin
        if (tcif.cmd_rdy && !rdy_prev)
            pulses = pulses + 1;
        rdy_prev = tcif.cmd_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built from the dx,dy move table.
    function automatic logic [15:0] model_cmd(input int b, input bit horiz, input bit last);
        int dx[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dy[8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};
        int d;
        logic [7:0] hdg;
        logic [3:0] opc;
        d = horiz ? dx[b] : dy[b];
        if (horiz) hdg = (d > 0) ? 8'hBF : 8'h3F;
        else       hdg = (d > 0) ? 8'h00 : 8'h7F;
        opc = (horiz && last) ? 4'b0011 : 4'b0010;
        return {opc, hdg, 4'((d < 0) ? -d : d)};
    endfunction

    initial begin
        rst = 1'b1; start_tour = 0; move = 8'h02; cmd_UART = 16'h0000; cmd_rdy_UART = 0;
        tcif.clr_cmd_rdy = 0; tcif.send_resp = 0;
        tick();
        rst = 1'b0;
        check("reset_idx", 32'(mv_indx), 32'd0);
        check("reset_rdy", 32'(tcif.cmd_rdy), 32'd0);
        check("reset_resp", 32'(tcif.resp), 32'h5A);

        // UART passthrough in IDLE
        cmd_UART = 16'h2BF3; cmd_rdy_UART = 1; #1;
        check("uart_cmd", 32'(tcif.cmd), 32'h2BF3);
        check("uart_rdy", 32'(tcif.cmd_rdy), 32'd1);
        cmd_rdy_UART = 0;

        // First move: +1,+2
        move = 8'h02; start_tour = 1; tick(); start_tour = 0;
        check("v_cmd", 32'(tcif.cmd), 32'h2002);
        check("v_rdy", 32'(tcif.cmd_rdy), 32'd1);
        check("v_resp", 32'(tcif.resp), 32'hA5);
        tcif.clr_cmd_rdy = 1; tick(); tcif.clr_cmd_rdy = 0;
        check("vhold_rdy", 32'(tcif.cmd_rdy), 32'd0);
        check("vhold_cmd", 32'(tcif.cmd), 32'h2002);
        tcif.send_resp = 1; tick(); tcif.send_resp = 0;
        check("h_cmd", 32'(tcif.cmd), 32'h2BF1);
        check("h_rdy", 32'(tcif.cmd_rdy), 32'd1);
        tcif.send_resp = 1; tick(); tcif.send_resp = 0;
        check("h_sendonly_rdy", 32'(tcif.cmd_rdy), 32'd1);
        check("h_sendonly_idx", 32'(mv_indx), 32'd0);
        tcif.clr_cmd_rdy = 1; tick(); tcif.clr_cmd_rdy = 0;
        check("hhold_rdy", 32'(tcif.cmd_rdy), 32'd0);
        check("hhold_resp", 32'(tcif.resp), 32'hA5);
        tcif.send_resp = 1; tick(); tcif.send_resp = 0;
        check("next_idx", 32'(mv_indx), 32'd1);
        check("next_rdy", 32'(tcif.cmd_rdy), 32'd1);

        // start_tour and UART traffic ignored mid-tour; -1,-2 move
        move = 8'h10; #1;
        check("v2_cmd", 32'(tcif.cmd), 32'h27F2);
        start_tour = 1; cmd_UART = 16'h1234; cmd_rdy_UART = 1; tick();
        start_tour = 0; cmd_rdy_UART = 0;
        check("midstart_cmd", 32'(tcif.cmd), 32'h27F2);
        check("midstart_idx", 32'(mv_indx), 32'd1);
        tcif.clr_cmd_rdy = 1; tcif.send_resp = 1; tick();
        check("both_v_cmd", 32'(tcif.cmd), 32'h23F1);
        check("both_v_rdy", 32'(tcif.cmd_rdy), 32'd1);
        tick(); tcif.clr_cmd_rdy = 0; tcif.send_resp = 0;
        check("both_h_idx", 32'(mv_indx), 32'd2);
        check("both_h_cmd", 32'(tcif.cmd), 32'h27F2);

        // Invalid moves become no-ops
        move = 8'h03; #1;
        check("multi_hot", 32'(tcif.cmd), 32'h0000);
        move = 8'h00; #1;
        check("zero_move", 32'(tcif.cmd), 32'h0000);
        check("zero_rdy", 32'(tcif.cmd_rdy), 32'd1);

        // Advance to idx 7 in V_HOLD, then reset
        move = 8'h01;
        for (int i = 2; i < 7; i++) begin
            tcif.clr_cmd_rdy = 1; tcif.send_resp = 1; tick(); tick();
        end
        tcif.send_resp = 0; tick(); tcif.clr_cmd_rdy = 0;
        check("pre_rst_idx", 32'(mv_indx), 32'd7);
        check("pre_rst_rdy", 32'(tcif.cmd_rdy), 32'd0);
        rst = 1; cmd_UART = 16'hBEEF; cmd_rdy_UART = 1; tick(); rst = 0;
        check("rst_idx", 32'(mv_indx), 32'd0);
        check("rst_rdy", 32'(tcif.cmd_rdy), 32'd1);
        check("rst_cmd", 32'(tcif.cmd), 32'hBEEF);
        check("rst_resp", 32'(tcif.resp), 32'h5A);
        cmd_rdy_UART = 0; tick();
        check("rst_noreissue", 32'(tcif.cmd_rdy), 32'd0);

        // Full 24-move replay
        pulses = 0;
        move = 8'h10; start_tour = 1; tick(); start_tour = 0;
        for (int i = 0; i < 24; i++) begin
            int b;
            b = (i + 4) % 8;
            move = 8'(1 << b); #1;
            check("tour_idx", 32'(mv_indx), 32'(i));
            check("tour_vcmd", 32'(tcif.cmd), 32'(model_cmd(b, 1'b0, 1'b0)));
            check("tour_vresp", 32'(tcif.resp), 32'hA5);
            tcif.clr_cmd_rdy = 1; tick(); tcif.clr_cmd_rdy = 0;
            tcif.send_resp = 1; tick(); tcif.send_resp = 0;
            check("tour_hcmd", 32'(tcif.cmd), 32'(model_cmd(b, 1'b1, i == 23)));
            if (i == 23) begin
                check("last_vcmd_const", 32'(model_cmd(b, 1'b0, 1'b0)), 32'h27F1);
                check("last_hcmd", 32'(tcif.cmd), 32'h33F2);
            end
            tcif.clr_cmd_rdy = 1; tick(); tcif.clr_cmd_rdy = 0;
            check("tour_hresp", 32'(tcif.resp), (i == 23) ? 32'h5A : 32'hA5);
            tcif.send_resp = 1; tick(); tcif.send_resp = 0;
        end
        check("tour_end_idx", 32'(mv_indx), 32'd0);
        check("tour_end_resp", 32'(tcif.resp), 32'h5A);
        check("tour_end_rdy", 32'(tcif.cmd_rdy), 32'd0);
        tick();
        check("tour_pulses", 32'(pulses), 32'd48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
